// File: rtl/jtpopeye_pkg.sv
// Shared constants and pixel types for the Popeye colour mixer.
package jtpopeye_pkg;
   localparam logic SEL_BAK      = 1'b0;
   localparam logic SEL_FG       = 1'b1;
   localparam int   PROM_SEL_BIT = 6;
   localparam int   RED_W        = 3;
   localparam int   GRN_W        = 3;
   localparam int   BLU_W        = 2;

   typedef struct packed {
      logic [RED_W-1:0] r;
      logic [GRN_W-1:0] g;
      logic [BLU_W-1:0] b;
   } rgb_t;

   function automatic rgb_t word2rgb(input logic [7:0] w);
      word2rgb = rgb_t'(w);
   endfunction
endpackage

// File: rtl/jtpopeye_colmix_if.sv
// PROM download bus: the loader drives address/data/strobe, the mixer consumes them.
interface jtpopeye_colmix_if;
   logic [6:0] prog_addr;
   logic [7:0] prog_data;
   logic       prog_we;

   modport master (output prog_addr, output prog_data, output prog_we);
   modport slave  (input  prog_addr, input  prog_data, input  prog_we);
endinterface

// File: rtl/jtpopeye_prom_dl.sv
// 64x8 palette PROM: synchronous read gated by i_cen, download write on every clk.
// A write to the address being read in the same cycle returns the old word.
module jtpopeye_prom_dl (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_cen,
   input  logic [5:0] i_rd_addr,
   output logic [7:0] o_q,
   input  logic       i_we,
   input  logic [5:0] i_wr_addr,
   input  logic [7:0] i_wr_data
);
   logic [7:0] r_mem [64];
   logic [7:0] r_q;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst)        r_q <= '0;
      else if (i_cen) r_q <= r_mem[i_rd_addr];
   end

   assign o_q = r_q;
endmodule

// File: rtl/jtpopeye_colmix.sv
// Layer priority, frame-synchronous palette bank and PROM lookup; 2 pxl_cen latency.
// Optional JTPOPEYE_LAYER_MASK_EN: gfx_en gates txt/obj/bak layers.
module jtpopeye_colmix
   import jtpopeye_pkg::*;
#(
   parameter int BLANK_DLY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pxl_cen,
   input  logic               cpu_cen,
   input  logic               pal_we,
   input  logic [7:0]         cpu_dout,
   input  logic [4:0]         BAKC,
   input  logic [3:0]         obj_pxl,
   input  logic [3:0]         txt_pxl,
   input  logic               LHBL,
   input  logic               LVBL,
   input  logic               HS,
   input  logic               VS,
   jtpopeye_colmix_if.slave   dl,
   input  logic [2:0]         gfx_en,
   output logic [RED_W-1:0]   red,
   output logic [GRN_W-1:0]   green,
   output logic [BLU_W-1:0]   blue,
   output logic               LHBL_dly,
   output logic               LVBL_dly,
   output logic               HS_dly,
   output logic               VS_dly
);
   generate
      if (BLANK_DLY != 2) begin : g_bad_blank_dly
         $error("BLANK_DLY must equal the 2-stage pixel latency");
      end
   endgenerate

   logic [2:0]           w_en;
   logic                 w_unused_cpu;
   logic                 w_txt_on;
   logic                 w_obj_on;
   logic [4:0]           w_bak_idx;
   logic [4:0]           w_fg_idx;
   logic                 w_sel;
   logic [7:0]           w_bak_q;
   logic [7:0]           w_fg_q;
   logic [7:0]           w_q;
   logic                 w_vis;
   rgb_t                 w_rgb;

   logic                 r_pend_bank;
   logic                 r_act_bank;
   logic                 r_lvbl_last;
   logic [5:0]           r_bak_addr;
   logic [5:0]           r_fg_addr;
   logic                 r_sel1;
   logic                 r_sel2;
   logic [BLANK_DLY-1:0] r_hbl;
   logic [BLANK_DLY-1:0] r_vbl;
   logic [BLANK_DLY-1:0] r_hs;
   logic [BLANK_DLY-1:0] r_vs;

`ifdef JTPOPEYE_LAYER_MASK_EN
   assign w_en = gfx_en;
`else
   logic w_unused_gfx;
   assign w_unused_gfx = ^gfx_en;
   assign w_en         = 3'b111;
`endif
   assign w_unused_cpu = ^cpu_dout[7:1];

   always_comb begin
      w_txt_on  = w_en[2] && (txt_pxl != 4'd0);
      w_obj_on  = w_en[1] && (obj_pxl != 4'd0);
      w_bak_idx = w_en[0] ? BAKC : 5'd0;
      w_fg_idx  = w_txt_on ? {1'b1, txt_pxl} : {1'b0, obj_pxl};
      w_sel     = (w_txt_on || w_obj_on) ? SEL_FG : SEL_BAK;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_bank <= 1'b0;
         r_act_bank  <= 1'b0;
         r_lvbl_last <= 1'b0;
         r_bak_addr  <= '0;
         r_fg_addr   <= '0;
         r_sel1      <= SEL_BAK;
         r_sel2      <= SEL_BAK;
         r_hbl       <= '0;
         r_vbl       <= '0;
         r_hs        <= '0;
         r_vs        <= '0;
      end else begin
         if (pal_we && cpu_cen) r_pend_bank <= cpu_dout[0];
         if (pxl_cen) begin
            // A bank write on this same edge is not yet visible: copy sees the old pending value
            r_lvbl_last <= LVBL;
            if (r_lvbl_last && !LVBL) r_act_bank <= r_pend_bank;
            r_bak_addr <= {r_act_bank, w_bak_idx};
            r_fg_addr  <= {r_act_bank, w_fg_idx};
            r_sel1     <= w_sel;
            r_sel2     <= r_sel1;
            r_hbl      <= {r_hbl[BLANK_DLY-2:0], LHBL};
            r_vbl      <= {r_vbl[BLANK_DLY-2:0], LVBL};
            r_hs       <= {r_hs[BLANK_DLY-2:0], HS};
            r_vs       <= {r_vs[BLANK_DLY-2:0], VS};
         end
      end
   end

   jtpopeye_prom_dl u_bak_prom (
      .clk       (clk),
      .rst       (rst),
      .i_cen     (pxl_cen),
      .i_rd_addr (r_bak_addr),
      .o_q       (w_bak_q),
      .i_we      (dl.prog_we && !dl.prog_addr[PROM_SEL_BIT]),
      .i_wr_addr (dl.prog_addr[5:0]),
      .i_wr_data (dl.prog_data)
   );

   jtpopeye_prom_dl u_fg_prom (
      .clk       (clk),
      .rst       (rst),
      .i_cen     (pxl_cen),
      .i_rd_addr (r_fg_addr),
      .o_q       (w_fg_q),
      .i_we      (dl.prog_we && dl.prog_addr[PROM_SEL_BIT]),
      .i_wr_addr (dl.prog_addr[5:0]),
      .i_wr_data (dl.prog_data)
   );

   // PROM word and delayed blanking both land on the second pxl_cen, so no extra register
   assign w_q   = (r_sel2 == SEL_FG) ? w_fg_q : w_bak_q;
   assign w_vis = r_hbl[BLANK_DLY-1] && r_vbl[BLANK_DLY-1];
   assign w_rgb = w_vis ? word2rgb(w_q) : '0;

   assign red      = w_rgb.r;
   assign green    = w_rgb.g;
   assign blue     = w_rgb.b;
   assign LHBL_dly = r_hbl[BLANK_DLY-1];
   assign LVBL_dly = r_vbl[BLANK_DLY-1];
   assign HS_dly   = r_hs[BLANK_DLY-1];
   assign VS_dly   = r_vs[BLANK_DLY-1];
endmodule

// File: tb/tb_jtpopeye_colmix.sv
// Scoreboard bench for jtpopeye_colmix: directed pixels, expected words pushed at issue time.
module tb_jtpopeye_colmix;
   import jtpopeye_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pxl_cen = 1'b0;
   logic       cpu_cen = 1'b0;
   logic       pal_we = 1'b0;
   logic [7:0] cpu_dout = 8'd0;
   logic [4:0] BAKC = 5'd0;
   logic [3:0] obj_pxl = 4'd0;
   logic [3:0] txt_pxl = 4'd0;
   logic       LHBL = 1'b0;
   logic       LVBL = 1'b0;
   logic       HS = 1'b0;
   logic       VS = 1'b0;
   logic [2:0] gfx_en = 3'b111;
   logic [2:0] red;
   logic [2:0] green;
   logic [1:0] blue;
   logic       LHBL_dly;
   logic       LVBL_dly;
   logic       HS_dly;
   logic       VS_dly;

   jtpopeye_colmix_if dl ();

   jtpopeye_colmix #(.BLANK_DLY(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .pxl_cen  (pxl_cen),
      .cpu_cen  (cpu_cen),
      .pal_we   (pal_we),
      .cpu_dout (cpu_dout),
      .BAKC     (BAKC),
      .obj_pxl  (obj_pxl),
      .txt_pxl  (txt_pxl),
      .LHBL     (LHBL),
      .LVBL     (LVBL),
      .HS       (HS),
      .VS       (VS),
      .dl       (dl),
      .gfx_en   (gfx_en),
      .red      (red),
      .green    (green),
      .blue     (blue),
      .LHBL_dly (LHBL_dly),
      .LVBL_dly (LVBL_dly),
      .HS_dly   (HS_dly),
      .VS_dly   (VS_dly)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       chk;
      logic [7:0] rgb;
      logic       hbl;
      logic       vbl;
   } exp_t;

   exp_t       sb_q[$];
   int         total = 0;
   int         bad = 0;
   int         pix_no = 0;
   logic       pw_req = 1'b0;
   logic       pd_req = 1'b0;
   logic       dl_req = 1'b0;
   logic [6:0] dl_a = 7'd0;
   logic [7:0] dl_d = 8'd0;
   logic [7:0] mask_exp;

   function automatic logic [11:0] out_vec();
      return {red, green, blue, LHBL_dly, LVBL_dly, HS_dly, VS_dly};
   endfunction

   // One pixel: inputs presented on a pxl_cen clock, then one idle clock
   task automatic pix(input logic [4:0] b, input logic [3:0] o, input logic [3:0] t,
                      input logic hbl, input logic vbl, input logic [7:0] e, input logic chk);
      exp_t x;
      BAKC = b; obj_pxl = o; txt_pxl = t;
      LHBL = hbl; LVBL = vbl; HS = ~hbl; VS = ~vbl;
      pxl_cen = 1'b1;
      if (pw_req) begin
         pal_we = 1'b1; cpu_cen = 1'b1; cpu_dout = {7'd0, pd_req}; pw_req = 1'b0;
      end
      if (dl_req) begin
         dl.prog_addr = dl_a; dl.prog_data = dl_d; dl.prog_we = 1'b1; dl_req = 1'b0;
      end
      x.chk = chk; x.rgb = e; x.hbl = hbl; x.vbl = vbl;
      sb_q.push_back(x);
      @(posedge clk); #1;
      pxl_cen = 1'b0; pal_we = 1'b0; cpu_cen = 1'b0; dl.prog_we = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic dl_wr(input logic [6:0] a, input logic [7:0] d);
      dl.prog_addr = a; dl.prog_data = d; dl.prog_we = 1'b1;
      @(posedge clk); #1;
      dl.prog_we = 1'b0;
   endtask

   task automatic chk_now(input string name, input logic [11:0] want);
      logic [11:0] act;
      act = out_vec();
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, want);
      end
   endtask

   // Monitor: entry consumed at pxl_cen edge j is checked after edge j+1
   initial begin : monitor
      exp_t        held;
      logic        hv;
      logic        cs;
      logic        rs;
      logic [11:0] act;
      logic [11:0] want;
      hv = 1'b0;
      forever begin
         @(posedge clk);
         cs = pxl_cen;
         rs = rst;
         #1;
         if (rs) begin
            hv = 1'b0;
            sb_q.delete();
         end else if (cs) begin
            if (hv && held.chk) begin
               act  = out_vec();
               want = {held.rgb, held.hbl, held.vbl, ~held.hbl, ~held.vbl};
               total++;
               if (act !== want) begin
                  bad++;
                  $display("FAIL pixel#%0d got=%h want=%h", pix_no, act, want);
               end
            end
            if (sb_q.size() > 0) begin
               held = sb_q.pop_front();
               hv   = 1'b1;
            end else begin
               hv = 1'b0;
            end
            pix_no++;
         end
      end
   end

   initial begin
`ifdef JTPOPEYE_LAYER_MASK_EN
      mask_exp = 8'h03;
`else
      mask_exp = 8'h1C;
`endif
      dl.prog_addr = 7'd0; dl.prog_data = 8'd0; dl.prog_we = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_now("reset_state", 12'h000);

      dl_wr(7'h05, 8'hE0);
      dl_wr(7'h25, 8'h5A);
      dl_wr(7'h53, 8'h1C);
      dl_wr(7'h47, 8'h03);
      rst = 1'b0;
      @(posedge clk); #1;

      // priority
      pix(5, 0, 0, 1, 1, 8'hE0, 1);
      pix(5, 7, 3, 1, 1, 8'h1C, 1);
      pix(5, 7, 0, 1, 1, 8'h03, 1);
      pix(5, 0, 0, 1, 1, 8'hE0, 1);
      pix(5, 0, 3, 1, 1, 8'h1C, 1);

      // horizontal blank, colourful inputs must not leak
      pix(5, 0, 0, 1, 1, 8'hE0, 1);
      for (int i = 0; i < 4; i++) pix(5, 7, 3, 0, 1, 8'h00, 1);
      pix(5, 0, 0, 1, 1, 8'hE0, 1);
      pix(5, 7, 0, 1, 1, 8'h03, 1);

      // bank write mid-frame: held until LVBL falls
      pw_req = 1'b1; pd_req = 1'b1;
      pix(5, 0, 0, 1, 1, 8'hE0, 1);
      for (int i = 0; i < 3; i++) pix(5, 0, 0, 1, 1, 8'hE0, 1);
      for (int i = 0; i < 3; i++) pix(5, 0, 0, 1, 0, 8'h00, 1);
      for (int i = 0; i < 3; i++) pix(5, 0, 0, 1, 1, 8'h5A, 1);

      // bank write on the LVBL edge: deferred one frame
      pw_req = 1'b1; pd_req = 1'b0;
      pix(5, 0, 0, 1, 0, 8'h00, 1);
      pix(5, 0, 0, 1, 0, 8'h00, 1);
      pix(5, 0, 0, 1, 1, 8'h5A, 1);
      pix(5, 0, 0, 1, 1, 8'h5A, 1);
      pix(5, 0, 0, 1, 0, 8'h00, 1);
      pix(5, 0, 0, 1, 0, 8'h00, 1);
      pix(5, 0, 0, 1, 1, 8'hE0, 1);
      pix(5, 0, 0, 1, 1, 8'hE0, 1);

      // download collision on bak PROM[5]
      pix(5, 0, 0, 1, 1, 8'hE0, 1);
      dl_req = 1'b1; dl_a = 7'h05; dl_d = 8'h4C;
      pix(5, 0, 0, 1, 1, 8'h4C, 1);
      pix(5, 0, 0, 1, 1, 8'h4C, 1);

      // layer mask
      gfx_en = 3'b011;
      pix(5, 7, 3, 1, 1, mask_exp, 1);
      gfx_en = 3'b111;
      pix(5, 7, 3, 1, 1, 8'h1C, 1);

      // bring bank 1 active, then reset mid-line
      pw_req = 1'b1; pd_req = 1'b1;
      pix(5, 0, 0, 1, 1, 8'h4C, 1);
      pix(5, 0, 0, 1, 0, 8'h00, 1);
      pix(5, 0, 0, 1, 0, 8'h00, 1);
      pix(5, 0, 0, 1, 1, 8'h5A, 1);
      pix(5, 0, 0, 1, 1, 8'h5A, 1);
      chk_now("pre_reset_visible", {8'h5A, 4'b1100});
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_now("mid_line_reset", 12'h000);
      @(posedge clk); #1;
      pix(5, 0, 0, 1, 1, 8'h4C, 1);
      pix(5, 0, 0, 1, 1, 8'h4C, 1);
      pix(5, 7, 0, 1, 1, 8'h03, 1);
      pix(0, 0, 0, 0, 0, 8'h00, 0);
      pix(0, 0, 0, 0, 0, 8'h00, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/jtpopeye_colmix.md
Name: jtpopeye_colmix

Overview:
- Colour mixer directly downstream of the background generator.
- Consumes the 5-bit background colour code BAKC, the object pixel and the text pixel, and resolves layer priority (text > object > background).
- Looks up 64x8 palette PROMs and drives RRRGGGBB video aligned with delayed blanking and sync.
- PROMs load over the standard download bus; a CPU-written palette bank bit is applied frame-synchronously.

Parameters:
- BLANK_DLY, 2: pxl_cen cycles by which LHBL/LVBL/HS/VS are delayed. Must equal pixel latency; only 2 is legal. Checked at elaboration.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pxl_cen  in  1  pixel clock enable
- cpu_cen  in  1  CPU clock enable
- pal_we  in  1  CPU strobe writing palette bank
- cpu_dout  in  8  CPU data; bit 0 is the requested palette bank
- BAKC  in  5  background colour code from background stage
- obj_pxl  in  4  object pixel; 0 = transparent
- txt_pxl  in  4  text pixel; 0 = transparent
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- HS  in  1  horizontal sync
- VS  in  1  vertical sync
- prog_addr  in  7  download address; bit 6: 0 = background PROM, 1 = foreground PROM
- prog_data  in  8  download data
- prog_we  in  1  download write strobe
- gfx_en  in  3  layer enables [0]=bak [1]=obj [2]=txt (only with the optional feature)
- red  out  3  colour
- green  out  3  colour
- blue  out  2  colour
- LHBL_dly  out  1  delayed blanking
- LVBL_dly  out  1  delayed blanking
- HS_dly  out  1  delayed sync
- VS_dly  out  1  delayed sync

Behaviour:
- Reset: red, green, blue = 0; all *_dly = 0 (blank asserted); pending bank = 0; active bank = 0; pipeline registers = 0. Reset mid-frame takes effect on the next clk edge regardless of pxl_cen.
- Bank register:
  - pal_we && cpu_cen latches cpu_dout[0] into pending bank.
  - Active bank copies pending bank on the LVBL falling edge (1->0), detected on pxl_cen.
  - pal_we on the same pxl_cen as the LVBL edge: the copy takes the old pending value; the new one applies next frame.
- Stage 1 (pxl_cen):
  - if txt_pxl != 0: fg index = {1, txt_pxl}, sel = fg
  - else if obj_pxl != 0: fg index = {0, obj_pxl}, sel = fg
  - else: bak index = BAKC, sel = bak
  - Registered PROM address = {active bank, 5-bit index}; 6 bits, one per PROM.
- Stage 2: both PROMs are synchronous reads with cen = pxl_cen. On the next pxl_cen, sel (delayed one stage) picks the PROM word.
  - red = q[7:5], green = q[4:2], blue = q[1:0].
  - Forced to 0 when the delayed LHBL or LVBL is low.
- Latency: input pixel to RGB is exactly 2 pxl_cen.
- Blank/sync: LHBL/LVBL/HS/VS go through a BLANK_DLY-deep shift register clocked on pxl_cen, so edges stay aligned with colour.
- Download: prog_we writes prog_data at prog_addr[5:0] into the PROM chosen by prog_addr[6]. Writes happen on clk without pxl_cen qualification.
  - A write coincident with a video read of the same address: the read returns old data.
  - No write occurs with prog_we low.
- No state changes when pxl_cen is low, except the download path and the cpu_cen bank latch.

Optional Feature:
- JTPOPEYE_LAYER_MASK_EN defined: gfx_en gates each layer.
  - A disabled txt or obj layer is treated as transparent.
  - A disabled background forces bak index 0.
- Undefined: gfx_en is ignored (port kept, tied internally); all layers are always enabled.

Decomposition:
- Shared package/include jtpopeye_pkg:
  - layer select constants SEL_BAK = 0, SEL_FG = 1
  - PROM select bit position 6
  - RGB field widths 3/3/2
- One sub-module: jtpopeye_prom_dl, a dual-use 64x8 synchronous ROM with download write port, instantiated twice.
- Priority, bank and delay logic stay in the top module.

Test Plan:
- Priority:
  - Setup: load bak PROM[5] = 8'hE0, fg PROM[0x13] = 8'h1C, fg PROM[0x07] = 8'h03; bank 0; blanks high.
  - BAKC = 5, obj = 7, txt = 3 -> RGB = 0/7/0 after 2 pxl_cen.
  - txt = 0 -> 0/0/3.
  - obj = 0 -> 7/0/0.
- Blanking: LHBL low for 4 pxl_cen mid-line -> RGB = 0 and LHBL_dly low for exactly those 4 cycles, delayed by 2 pxl_cen; no colour leak at either edge.
- Bank timing:
  - Write cpu_dout = 1 mid-frame -> output still uses bank 0 until the LVBL falling edge, then bank-1 address 0x25.
  - Write coincident with the LVBL edge -> bank change deferred one frame.
- Reset: assert rst for 1 clk mid-line -> next clk RGB = 0, all *_dly = 0, active bank = 0; after release, the pipeline refills in 2 pxl_cen.
- Download collision: prog_we to bak PROM[5] during an active-video read of index 5 -> that pixel shows old value 8'hE0, the following pixel shows the new value.
- With JTPOPEYE_LAYER_MASK_EN and gfx_en = 3'b011: txt = 3, obj = 7 -> object colour 0/0/3 shown. With the macro undefined, same stimulus -> 0/7/0.
